// File: rtl/apb_rr_arbiter.sv
// Round-robin arbiter sharing one APB master port between N_REQ valid/ready requesters.
// Optional ACCESS-phase timeout enabled by defining APB_ARB_TIMEOUT_EN.
module apb_rr_arbiter #(
    parameter int unsigned N_REQ       = 2,
    parameter int unsigned APB_AW      = 32,
    parameter int unsigned APB_DW      = 32,
    parameter int unsigned TIMEOUT_CYC = 256
) (
    input  logic                       pclk,
    input  logic                       prst,
    input  logic [N_REQ-1:0]           req_valid,
    output logic [N_REQ-1:0]           req_ready,
    input  logic [N_REQ*APB_AW-1:0]    req_addr,
    input  logic [N_REQ-1:0]           req_write,
    input  logic [N_REQ*APB_DW-1:0]    req_wdata,
    input  logic [N_REQ*APB_DW/8-1:0]  req_strb,
    output logic [N_REQ-1:0]           rsp_valid,
    output logic [APB_DW-1:0]          rsp_rdata,
    output logic                       rsp_slverr,
    output logic [APB_AW-1:0]          m_apb_paddr,
    output logic                       m_apb_psel,
    output logic                       m_apb_penable,
    output logic                       m_apb_pwrite,
    output logic [APB_DW-1:0]          m_apb_pwdata,
    output logic [APB_DW/8-1:0]        m_apb_pstrb,
    input  logic                       m_apb_pready,
    input  logic [APB_DW-1:0]          m_apb_prdata,
    input  logic                       m_apb_pslverr
);

    localparam int unsigned STRB_W = APB_DW / 8;
    localparam int unsigned IDX_W  = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    if (N_REQ < 2 || N_REQ > 8 || TIMEOUT_CYC < 2) begin : g_bad_cfg
        $error("apb_rr_arbiter: unsupported parameter set");
    end

    typedef enum logic [1:0] {ST_IDLE, ST_SETUP, ST_ACCESS} state_e;

    state_e              state_q, state_d;
    logic [IDX_W-1:0]    last_q, last_d;
    logic [IDX_W-1:0]    owner_q, owner_d;
    logic                psel_q, psel_d;
    logic                penable_q, penable_d;
    logic                pwrite_q, pwrite_d;
    logic [APB_AW-1:0]   paddr_q, paddr_d;
    logic [APB_DW-1:0]   pwdata_q, pwdata_d;
    logic [STRB_W-1:0]   pstrb_q, pstrb_d;
    logic [N_REQ-1:0]    rsp_valid_q, rsp_valid_d;
    logic [APB_DW-1:0]   rsp_rdata_q, rsp_rdata_d;
    logic                rsp_slverr_q, rsp_slverr_d;

    logic                win_found;
    logic [IDX_W-1:0]    win_idx;
    logic [IDX_W-1:0]    cand;

`ifdef APB_ARB_TIMEOUT_EN
    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYC) + 1;
    logic [CNT_W-1:0]    wait_cnt_q, wait_cnt_d;
`endif

    // Scan from the farthest candidate down so the one closest after last_q wins.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        cand      = '0;
        for (int off = int'(N_REQ); off >= 1; off--) begin
            cand = IDX_W'((int'(last_q) + off) % int'(N_REQ));
            if (req_valid[cand]) begin
                win_found = 1'b1;
                win_idx   = cand;
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        last_d       = last_q;
        owner_d      = owner_q;
        pwrite_d     = pwrite_q;
        paddr_d      = paddr_q;
        pwdata_d     = pwdata_q;
        pstrb_d      = pstrb_q;
        rsp_valid_d  = '0;
        rsp_rdata_d  = rsp_rdata_q;
        rsp_slverr_d = rsp_slverr_q;
        req_ready    = '0;
`ifdef APB_ARB_TIMEOUT_EN
        wait_cnt_d   = wait_cnt_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (win_found) begin
                    req_ready[win_idx] = 1'b1;
                    paddr_d  = req_addr[int'(win_idx)*APB_AW +: APB_AW];
                    pwrite_d = req_write[win_idx];
                    pwdata_d = req_wdata[int'(win_idx)*APB_DW +: APB_DW];
                    pstrb_d  = req_write[win_idx] ? req_strb[int'(win_idx)*STRB_W +: STRB_W] : '0;
                    owner_d  = win_idx;
                    last_d   = win_idx;
                    state_d  = ST_SETUP;
                end
            end
            ST_SETUP: begin
                state_d = ST_ACCESS;
`ifdef APB_ARB_TIMEOUT_EN
                wait_cnt_d = '0;
`endif
            end
            ST_ACCESS: begin
                if (m_apb_pready) begin
                    rsp_valid_d[owner_q] = 1'b1;
                    rsp_rdata_d  = pwrite_q ? '0 : m_apb_prdata;
                    rsp_slverr_d = m_apb_pslverr;
                    state_d      = ST_IDLE;
                end
`ifdef APB_ARB_TIMEOUT_EN
                // Unresponsive slave: terminate with an error response.
                else if (wait_cnt_q == CNT_W'(TIMEOUT_CYC - 1)) begin
                    rsp_valid_d[owner_q] = 1'b1;
                    rsp_rdata_d  = '0;
                    rsp_slverr_d = 1'b1;
                    state_d      = ST_IDLE;
                end else begin
                    wait_cnt_d = wait_cnt_q + CNT_W'(1);
                end
`endif
            end
            default: state_d = ST_IDLE;
        endcase
        psel_d    = (state_d != ST_IDLE);
        penable_d = (state_d == ST_ACCESS);
    end

    always_ff @(posedge pclk) begin
        if (prst) begin
            state_q      <= ST_IDLE;
            last_q       <= IDX_W'(N_REQ - 1);
            owner_q      <= '0;
            psel_q       <= 1'b0;
            penable_q    <= 1'b0;
            pwrite_q     <= 1'b0;
            paddr_q      <= '0;
            pwdata_q     <= '0;
            pstrb_q      <= '0;
            rsp_valid_q  <= '0;
            rsp_rdata_q  <= '0;
            rsp_slverr_q <= 1'b0;
`ifdef APB_ARB_TIMEOUT_EN
            wait_cnt_q   <= '0;
`endif
        end else begin
            state_q      <= state_d;
            last_q       <= last_d;
            owner_q      <= owner_d;
            psel_q       <= psel_d;
            penable_q    <= penable_d;
            pwrite_q     <= pwrite_d;
            paddr_q      <= paddr_d;
            pwdata_q     <= pwdata_d;
            pstrb_q      <= pstrb_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_rdata_q  <= rsp_rdata_d;
            rsp_slverr_q <= rsp_slverr_d;
`ifdef APB_ARB_TIMEOUT_EN
            wait_cnt_q   <= wait_cnt_d;
`endif
        end
    end

    assign m_apb_psel    = psel_q;
    assign m_apb_penable = penable_q;
    assign m_apb_pwrite  = pwrite_q;
    assign m_apb_paddr   = paddr_q;
    assign m_apb_pwdata  = pwdata_q;
    assign m_apb_pstrb   = pstrb_q;
    assign rsp_valid     = rsp_valid_q;
    assign rsp_rdata     = rsp_rdata_q;
    assign rsp_slverr    = rsp_slverr_q;

endmodule
